// File: rtl/branch_ckpt_stack_pkg.sv
// branch_ckpt_stack_pkg: shared sizes, checkpoint entry layout and one-hot helpers.
package branch_ckpt_stack_pkg;
  localparam int NUM_CKPT = 4;
  localparam int ALLOC_W = 2;
  localparam int RES_W = 2;
  localparam int ROB_IDX_W = 5;
  localparam int LSQ_IDX_W = 4;
  localparam int NUM_PHYS = 64;
  localparam int NUM_ARCH = 32;
  localparam int PREG_W = 6;
  localparam int CNT_W = $clog2(NUM_CKPT + 1);
  localparam int IDX_W = $clog2(NUM_CKPT);
  typedef struct packed {
    logic valid;
    logic [NUM_CKPT-1:0] dep_mask;
    logic [31:0] pc;
    logic [ROB_IDX_W-1:0] rob_tail;
    logic [LSQ_IDX_W-1:0] lsq_tail;
    logic [NUM_PHYS-1:0] free_list;
    logic [NUM_ARCH*PREG_W-1:0] map_table;
  } ckpt_entry_t;
  function automatic logic [NUM_CKPT-1:0] lowest_one(input logic [NUM_CKPT-1:0] v);
    return v & (~v + 1'b1);
  endfunction
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_CKPT-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CKPT; i++)
      if (v[i]) idx = idx | IDX_W'(i);
    return idx;
  endfunction
endpackage

// File: rtl/branch_ckpt_stack_alloc_sel.sv
// ckpt_alloc_sel: in-order multi-grant selector handing out the lowest free slots.
module ckpt_alloc_sel #(
  parameter int N = 4,
  parameter int A = 2
) (
  input  logic         en,
  input  logic [N-1:0] free_vec,
  input  logic [A-1:0] req,
  output logic [A-1:0] gnt,
  output logic [A*N-1:0] tag
);
  logic [N-1:0] avail;
  logic ok;
  always_comb begin
    avail = free_vec;
    ok = en;
    gnt = '0;
    tag = '0;
    for (int k = 0; k < A; k++)
      if (req[k]) begin
        if (ok && |avail) begin
          tag[k*N +: N] = avail & (~avail + 1'b1);
          avail = avail & ~tag[k*N +: N];
          gnt[k] = 1'b1;
        end else ok = 1'b0;
      end
  end
endmodule

// File: rtl/branch_ckpt_stack.sv
// branch_ckpt_stack: checkpoint slot allocation, dependency tracking and
// same-cycle restore/squash on the oldest mispredicting branch.
module branch_ckpt_stack
  import branch_ckpt_stack_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic [ALLOC_W-1:0] alloc_req,
  input  logic [ALLOC_W*32-1:0] alloc_pc,
  input  logic [ALLOC_W*ROB_IDX_W-1:0] alloc_rob_tail,
  input  logic [ALLOC_W*LSQ_IDX_W-1:0] alloc_lsq_tail,
  input  logic [ALLOC_W*NUM_PHYS-1:0] alloc_free_list,
  input  logic [ALLOC_W*NUM_ARCH*PREG_W-1:0] alloc_map_table,
  output logic [ALLOC_W-1:0] alloc_gnt,
  output logic [ALLOC_W*NUM_CKPT-1:0] alloc_tag,
  input  logic [RES_W-1:0] res_valid,
  input  logic [RES_W*NUM_CKPT-1:0] res_tag,
  input  logic [RES_W-1:0] res_mispred,
  output logic [NUM_CKPT-1:0] live_mask,
  output logic [CNT_W-1:0] free_count,
  output logic [NUM_CKPT-1:0] clear_mask,
  output logic [NUM_CKPT-1:0] squash_mask,
  output logic restore_valid,
  output logic [31:0] restore_pc,
  output logic [ROB_IDX_W-1:0] restore_rob_tail,
  output logic [LSQ_IDX_W-1:0] restore_lsq_tail,
  output logic [NUM_PHYS-1:0] restore_free_list,
  output logic [NUM_ARCH*PREG_W-1:0] restore_map_table
);
  ckpt_entry_t [NUM_CKPT-1:0] slot_q, slot_d;
  logic [CNT_W-1:0] free_count_q, free_count_d;
  logic [NUM_CKPT-1:0] valid, mis_set, m_tag, kill, lower;
  logic [RES_W-1:0] eff;
  logic [IDX_W-1:0] m_idx;
  logic [NUM_CKPT-1:0] rtag;
  always_comb
    for (int i = 0; i < NUM_CKPT; i++) valid[i] = slot_q[i].valid;
  assign live_mask = valid;
  assign free_count = free_count_q;
  always_comb begin
    eff = '0;
    mis_set = '0;
    m_tag = '0;
    restore_valid = 1'b0;
    clear_mask = '0;
    rtag = '0;
    for (int r = 0; r < RES_W; r++) begin
      eff[r] = res_valid[r] && |(res_tag[r*NUM_CKPT +: NUM_CKPT] & valid);
      if (eff[r] && res_mispred[r]) mis_set = mis_set | res_tag[r*NUM_CKPT +: NUM_CKPT];
    end
    // The oldest mispredict is the one that depends on no other mispredicting tag.
    for (int r = 0; r < RES_W; r++) begin
      rtag = res_tag[r*NUM_CKPT +: NUM_CKPT];
      if (!restore_valid && eff[r] && res_mispred[r] &&
          !(|(slot_q[onehot_idx(rtag)].dep_mask & mis_set))) begin
        restore_valid = 1'b1;
        m_tag = lowest_one(rtag);
      end
    end
    m_idx = onehot_idx(m_tag);
    for (int i = 0; i < NUM_CKPT; i++)
      squash_mask[i] = restore_valid && (m_tag[i] || (valid[i] && |(slot_q[i].dep_mask & m_tag)));
    for (int r = 0; r < RES_W; r++)
      if (eff[r] && !res_mispred[r]) clear_mask = clear_mask | res_tag[r*NUM_CKPT +: NUM_CKPT];
    clear_mask = clear_mask & valid & ~squash_mask;
    kill = squash_mask | clear_mask;
  end
  assign restore_pc = restore_valid ? slot_q[m_idx].pc : '0;
  assign restore_rob_tail = restore_valid ? slot_q[m_idx].rob_tail : '0;
  assign restore_lsq_tail = restore_valid ? slot_q[m_idx].lsq_tail : '0;
  assign restore_free_list = restore_valid ? slot_q[m_idx].free_list : '0;
  assign restore_map_table = restore_valid ? slot_q[m_idx].map_table : '0;
  ckpt_alloc_sel #(.N(NUM_CKPT), .A(ALLOC_W)) u_alloc_sel (
    .en(!restore_valid),
    .free_vec(~valid),
    .req(alloc_req),
    .gnt(alloc_gnt),
    .tag(alloc_tag)
  );
  always_comb begin
    slot_d = slot_q;
    lower = '0;
    free_count_d = '0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      if (kill[i]) slot_d[i].valid = 1'b0;
      slot_d[i].dep_mask = slot_q[i].dep_mask & ~kill;
    end
    for (int k = 0; k < ALLOC_W; k++)
      if (alloc_gnt[k]) begin
        slot_d[onehot_idx(alloc_tag[k*NUM_CKPT +: NUM_CKPT])].valid = 1'b1;
        slot_d[onehot_idx(alloc_tag[k*NUM_CKPT +: NUM_CKPT])].dep_mask = (valid & ~kill) | lower;
        slot_d[onehot_idx(alloc_tag[k*NUM_CKPT +: NUM_CKPT])].pc = alloc_pc[k*32 +: 32];
        slot_d[onehot_idx(alloc_tag[k*NUM_CKPT +: NUM_CKPT])].rob_tail = alloc_rob_tail[k*ROB_IDX_W +: ROB_IDX_W];
        slot_d[onehot_idx(alloc_tag[k*NUM_CKPT +: NUM_CKPT])].lsq_tail = alloc_lsq_tail[k*LSQ_IDX_W +: LSQ_IDX_W];
        slot_d[onehot_idx(alloc_tag[k*NUM_CKPT +: NUM_CKPT])].free_list = alloc_free_list[k*NUM_PHYS +: NUM_PHYS];
        slot_d[onehot_idx(alloc_tag[k*NUM_CKPT +: NUM_CKPT])].map_table = alloc_map_table[k*NUM_ARCH*PREG_W +: NUM_ARCH*PREG_W];
        lower = lower | alloc_tag[k*NUM_CKPT +: NUM_CKPT];
      end
    for (int i = 0; i < NUM_CKPT; i++)
      if (!slot_d[i].valid) free_count_d = free_count_d + 1'b1;
  end
  always_ff @(posedge clock)
    if (reset) begin
      slot_q <= '0;
      free_count_q <= CNT_W'(NUM_CKPT);
    end else begin
      slot_q <= slot_d;
      free_count_q <= free_count_d;
    end
endmodule

// File: tb/tb_branch_ckpt_stack.sv
// tb_branch_ckpt_stack: directed scenarios plus randomized traffic against an
// age-ordered queue model of the checkpoint stack.
module tb_branch_ckpt_stack;
  import branch_ckpt_stack_pkg::*;
  logic clock = 1'b0;
  logic reset;
  logic [ALLOC_W-1:0] alloc_req;
  logic [ALLOC_W*32-1:0] alloc_pc;
  logic [ALLOC_W*ROB_IDX_W-1:0] alloc_rob_tail;
  logic [ALLOC_W*LSQ_IDX_W-1:0] alloc_lsq_tail;
  logic [ALLOC_W*NUM_PHYS-1:0] alloc_free_list;
  logic [ALLOC_W*NUM_ARCH*PREG_W-1:0] alloc_map_table;
  logic [ALLOC_W-1:0] alloc_gnt;
  logic [ALLOC_W*NUM_CKPT-1:0] alloc_tag;
  logic [RES_W-1:0] res_valid;
  logic [RES_W*NUM_CKPT-1:0] res_tag;
  logic [RES_W-1:0] res_mispred;
  logic [NUM_CKPT-1:0] live_mask, clear_mask, squash_mask;
  logic [CNT_W-1:0] free_count;
  logic restore_valid;
  logic [31:0] restore_pc;
  logic [ROB_IDX_W-1:0] restore_rob_tail;
  logic [LSQ_IDX_W-1:0] restore_lsq_tail;
  logic [NUM_PHYS-1:0] restore_free_list;
  logic [NUM_ARCH*PREG_W-1:0] restore_map_table;
  int n_vec = 0;
  int n_err = 0;
  int q[$];
  logic [31:0] m_pc[NUM_CKPT];
  logic [ROB_IDX_W-1:0] m_rob[NUM_CKPT];
  logic [LSQ_IDX_W-1:0] m_lsq[NUM_CKPT];
  logic [NUM_PHYS-1:0] m_fl[NUM_CKPT];
  logic [NUM_ARCH*PREG_W-1:0] m_mt[NUM_CKPT];

  always #5 clock = ~clock;

  branch_ckpt_stack dut (
    .clock(clock), .reset(reset),
    .alloc_req(alloc_req), .alloc_pc(alloc_pc), .alloc_rob_tail(alloc_rob_tail),
    .alloc_lsq_tail(alloc_lsq_tail), .alloc_free_list(alloc_free_list),
    .alloc_map_table(alloc_map_table), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_mispred(res_mispred),
    .live_mask(live_mask), .free_count(free_count), .clear_mask(clear_mask),
    .squash_mask(squash_mask), .restore_valid(restore_valid), .restore_pc(restore_pc),
    .restore_rob_tail(restore_rob_tail), .restore_lsq_tail(restore_lsq_tail),
    .restore_free_list(restore_free_list), .restore_map_table(restore_map_table)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alloc_req = '0;
    alloc_pc = '0;
    alloc_rob_tail = '0;
    alloc_lsq_tail = '0;
    alloc_free_list = '0;
    alloc_map_table = '0;
    res_valid = '0;
    res_tag = '0;
    res_mispred = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    q.delete();
  endtask

  task automatic alloc_set(input int k, input logic [31:0] pc);
    alloc_req[k] = 1'b1;
    alloc_pc[k*32 +: 32] = pc;
    alloc_rob_tail[k*ROB_IDX_W +: ROB_IDX_W] = ROB_IDX_W'($urandom);
    alloc_lsq_tail[k*LSQ_IDX_W +: LSQ_IDX_W] = LSQ_IDX_W'($urandom);
    alloc_free_list[k*NUM_PHYS +: NUM_PHYS] = {$urandom, $urandom};
    for (int w = 0; w < NUM_ARCH*PREG_W/32; w++)
      alloc_map_table[k*NUM_ARCH*PREG_W + w*32 +: 32] = $urandom;
  endtask

  task automatic res_set(input int r, input logic [NUM_CKPT-1:0] tag, input logic mis);
    res_valid[r] = 1'b1;
    res_tag[r*NUM_CKPT +: NUM_CKPT] = tag;
    res_mispred[r] = mis;
  endtask

  task automatic build_chain();
    do_reset();
    alloc_set(0, 32'h40);
    alloc_set(1, 32'h100);
    tick();
    idle();
    alloc_set(0, 32'h200);
    tick();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec += 6;
    if (live_mask !== 4'b0) begin n_err++; $display("FAIL reset_live got %b want 0000", live_mask); end
    if (free_count !== CNT_W'(4)) begin n_err++; $display("FAIL reset_free got %0d want 4", free_count); end
    if (restore_valid !== 1'b0) begin n_err++; $display("FAIL reset_restore got %b want 0", restore_valid); end
    if (squash_mask !== 4'b0) begin n_err++; $display("FAIL reset_squash got %b want 0000", squash_mask); end
    if (clear_mask !== 4'b0) begin n_err++; $display("FAIL reset_clear got %b want 0000", clear_mask); end
    if (alloc_gnt !== 2'b0 || alloc_tag !== 8'b0) begin n_err++; $display("FAIL reset_gnt got %b/%b want 00/0", alloc_gnt, alloc_tag); end
  endtask

  task automatic test_alloc_pair();
    do_reset();
    alloc_set(0, 32'h10);
    alloc_set(1, 32'h20);
    #1;
    n_vec += 2;
    if (alloc_gnt !== 2'b11) begin n_err++; $display("FAIL pair_gnt got %b want 11", alloc_gnt); end
    if (alloc_tag !== 8'b0010_0001) begin n_err++; $display("FAIL pair_tag got %b want 00100001", alloc_tag); end
    tick();
    idle();
    #1;
    n_vec += 2;
    if (live_mask !== 4'b0011) begin n_err++; $display("FAIL pair_live got %b want 0011", live_mask); end
    if (free_count !== CNT_W'(2)) begin n_err++; $display("FAIL pair_free got %0d want 2", free_count); end
    res_set(0, 4'b0001, 1'b1);
    #1;
    n_vec += 2;
    if (squash_mask !== 4'b0011) begin n_err++; $display("FAIL pair_dep_squash got %b want 0011", squash_mask); end
    if (restore_pc !== 32'h10) begin n_err++; $display("FAIL pair_restore_pc got %h want 00000010", restore_pc); end
    tick();
    idle();
  endtask

  task automatic test_full();
    do_reset();
    alloc_set(0, 32'h1);
    alloc_set(1, 32'h2);
    tick();
    alloc_set(0, 32'h3);
    alloc_set(1, 32'h4);
    tick();
    idle();
    #1;
    n_vec += 2;
    if (free_count !== CNT_W'(0)) begin n_err++; $display("FAIL full_free got %0d want 0", free_count); end
    if (live_mask !== 4'b1111) begin n_err++; $display("FAIL full_live got %b want 1111", live_mask); end
    alloc_set(0, 32'h5);
    res_set(0, 4'b0100, 1'b0);
    #1;
    n_vec += 2;
    if (alloc_gnt !== 2'b00) begin n_err++; $display("FAIL full_gnt got %b want 00", alloc_gnt); end
    if (clear_mask !== 4'b0100) begin n_err++; $display("FAIL full_clear got %b want 0100", clear_mask); end
    tick();
    idle();
    alloc_set(0, 32'h6);
    #1;
    n_vec += 3;
    if (free_count !== CNT_W'(1)) begin n_err++; $display("FAIL full_free_after got %0d want 1", free_count); end
    if (alloc_gnt !== 2'b01) begin n_err++; $display("FAIL full_regnt got %b want 01", alloc_gnt); end
    if (alloc_tag[3:0] !== 4'b0100) begin n_err++; $display("FAIL full_retag got %b want 0100", alloc_tag[3:0]); end
    tick();
    idle();
  endtask

  task automatic test_chain_mispred();
    build_chain();
    res_set(0, 4'b0010, 1'b1);
    #1;
    n_vec += 4;
    if (restore_valid !== 1'b1) begin n_err++; $display("FAIL chain_restore got %b want 1", restore_valid); end
    if (restore_pc !== 32'h100) begin n_err++; $display("FAIL chain_pc got %h want 00000100", restore_pc); end
    if (squash_mask !== 4'b0110) begin n_err++; $display("FAIL chain_squash got %b want 0110", squash_mask); end
    if (clear_mask !== 4'b0000) begin n_err++; $display("FAIL chain_clear got %b want 0000", clear_mask); end
    tick();
    idle();
    #1;
    n_vec++;
    if (live_mask !== 4'b0001) begin n_err++; $display("FAIL chain_live got %b want 0001", live_mask); end
  endtask

  task automatic test_dual_mispred();
    build_chain();
    res_set(0, 4'b0100, 1'b1);
    res_set(1, 4'b0001, 1'b1);
    #1;
    n_vec += 2;
    if (restore_pc !== 32'h40) begin n_err++; $display("FAIL dual_pc got %h want 00000040", restore_pc); end
    if (squash_mask !== 4'b0111) begin n_err++; $display("FAIL dual_squash got %b want 0111", squash_mask); end
    tick();
    idle();
    #1;
    n_vec++;
    if (free_count !== CNT_W'(4)) begin n_err++; $display("FAIL dual_free got %0d want 4", free_count); end
  endtask

  task automatic test_clear_and_mispred();
    build_chain();
    res_set(0, 4'b0001, 1'b0);
    res_set(1, 4'b0010, 1'b1);
    #1;
    n_vec += 2;
    if (clear_mask !== 4'b0001) begin n_err++; $display("FAIL cm_clear got %b want 0001", clear_mask); end
    if (squash_mask !== 4'b0110) begin n_err++; $display("FAIL cm_squash got %b want 0110", squash_mask); end
    tick();
    idle();
    #1;
    n_vec++;
    if (live_mask !== 4'b0000) begin n_err++; $display("FAIL cm_live got %b want 0000", live_mask); end
  endtask

  task automatic test_flush_alloc();
    build_chain();
    res_set(0, 4'b0100, 1'b1);
    alloc_set(0, 32'h7);
    alloc_set(1, 32'h8);
    #1;
    n_vec += 2;
    if (alloc_gnt !== 2'b00) begin n_err++; $display("FAIL flush_gnt got %b want 00", alloc_gnt); end
    if (squash_mask !== 4'b0100) begin n_err++; $display("FAIL flush_squash got %b want 0100", squash_mask); end
    tick();
    idle();
    res_set(0, 4'b1000, 1'b1);
    #1;
    n_vec += 4;
    if (free_count !== CNT_W'(2)) begin n_err++; $display("FAIL flush_free got %0d want 2", free_count); end
    if (restore_valid !== 1'b0) begin n_err++; $display("FAIL dead_restore got %b want 0", restore_valid); end
    if (squash_mask !== 4'b0) begin n_err++; $display("FAIL dead_squash got %b want 0000", squash_mask); end
    if (restore_pc !== 32'b0) begin n_err++; $display("FAIL dead_pc got %h want 0", restore_pc); end
    tick();
    idle();
  endtask

  task automatic test_mid_reset();
    build_chain();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    res_set(0, 4'b0001, 1'b1);
    #1;
    n_vec += 2;
    if (restore_valid !== 1'b0) begin n_err++; $display("FAIL midrst_restore got %b want 0", restore_valid); end
    if (live_mask !== 4'b0) begin n_err++; $display("FAIL midrst_live got %b want 0000", live_mask); end
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [NUM_CKPT-1:0] live, e_sq, e_cl, kill, e_lv;
    logic [ALLOC_W-1:0] e_gnt;
    logic [ALLOC_W*NUM_CKPT-1:0] e_tag;
    int e_m, e_pos, pos, nq[$], fr[$], gs[ALLOC_W];
    bit stop;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle();
      for (int k = 0; k < ALLOC_W; k++)
        if ($urandom_range(1, 0) == 1) alloc_set(k, $urandom);
      for (int r = 0; r < RES_W; r++)
        if ($urandom_range(1, 0) == 1) res_set(r, 4'b0001 << $urandom_range(3, 0), $urandom_range(4, 0) == 0);
      #1;
      live = '0;
      foreach (q[i]) live[q[i]] = 1'b1;
      e_m = -1;
      e_pos = 99;
      for (int r = 0; r < RES_W; r++)
        if (res_valid[r] && res_mispred[r] && |(res_tag[r*4 +: 4] & live))
          foreach (q[i])
            if (res_tag[r*4 + q[i]] && i < e_pos) begin e_pos = i; e_m = q[i]; end
      e_sq = '0;
      foreach (q[i]) if (e_m >= 0 && i >= e_pos) e_sq[q[i]] = 1'b1;
      e_cl = '0;
      for (int r = 0; r < RES_W; r++)
        if (res_valid[r] && !res_mispred[r]) e_cl |= res_tag[r*4 +: 4] & live;
      e_cl &= ~e_sq;
      e_gnt = '0;
      e_tag = '0;
      fr.delete();
      for (int s = 0; s < NUM_CKPT; s++) if (!live[s]) fr.push_back(s);
      stop = (e_m >= 0);
      for (int k = 0; k < ALLOC_W; k++) begin
        gs[k] = -1;
        if (alloc_req[k] && !stop) begin
          if (fr.size() > 0) begin
            gs[k] = fr.pop_front();
            e_gnt[k] = 1'b1;
            e_tag[k*4 + gs[k]] = 1'b1;
          end else stop = 1'b1;
        end
      end
      n_vec += 9;
      if (alloc_gnt !== e_gnt) begin n_err++; $display("FAIL rnd_gnt c=%0d got %b want %b", c, alloc_gnt, e_gnt); end
      if (alloc_tag !== e_tag) begin n_err++; $display("FAIL rnd_tag c=%0d got %b want %b", c, alloc_tag, e_tag); end
      if (squash_mask !== e_sq) begin n_err++; $display("FAIL rnd_squash c=%0d got %b want %b", c, squash_mask, e_sq); end
      if (clear_mask !== e_cl) begin n_err++; $display("FAIL rnd_clear c=%0d got %b want %b", c, clear_mask, e_cl); end
      if (restore_valid !== (e_m >= 0)) begin n_err++; $display("FAIL rnd_rvalid c=%0d got %b want %b", c, restore_valid, e_m >= 0); end
      if (restore_pc !== (e_m >= 0 ? m_pc[e_m] : 32'b0)) begin n_err++; $display("FAIL rnd_pc c=%0d got %h", c, restore_pc); end
      if (restore_rob_tail !== (e_m >= 0 ? m_rob[e_m] : 5'b0) || restore_lsq_tail !== (e_m >= 0 ? m_lsq[e_m] : 4'b0))
        begin n_err++; $display("FAIL rnd_tails c=%0d got %h/%h", c, restore_rob_tail, restore_lsq_tail); end
      if (restore_free_list !== (e_m >= 0 ? m_fl[e_m] : 64'b0)) begin n_err++; $display("FAIL rnd_fl c=%0d got %h", c, restore_free_list); end
      if (restore_map_table !== (e_m >= 0 ? m_mt[e_m] : 192'b0)) begin n_err++; $display("FAIL rnd_mt c=%0d got %h", c, restore_map_table); end
      kill = e_sq | e_cl;
      nq.delete();
      foreach (q[i]) if (!kill[q[i]]) nq.push_back(q[i]);
      for (int k = 0; k < ALLOC_W; k++)
        if (gs[k] >= 0) begin
          nq.push_back(gs[k]);
          m_pc[gs[k]] = alloc_pc[k*32 +: 32];
          m_rob[gs[k]] = alloc_rob_tail[k*ROB_IDX_W +: ROB_IDX_W];
          m_lsq[gs[k]] = alloc_lsq_tail[k*LSQ_IDX_W +: LSQ_IDX_W];
          m_fl[gs[k]] = alloc_free_list[k*NUM_PHYS +: NUM_PHYS];
          m_mt[gs[k]] = alloc_map_table[k*NUM_ARCH*PREG_W +: NUM_ARCH*PREG_W];
        end
      q = nq;
      tick();
      e_lv = '0;
      foreach (q[i]) e_lv[q[i]] = 1'b1;
      n_vec += 2;
      if (live_mask !== e_lv) begin n_err++; $display("FAIL rnd_live c=%0d got %b want %b", c, live_mask, e_lv); end
      if (free_count !== CNT_W'(NUM_CKPT - q.size())) begin n_err++; $display("FAIL rnd_free c=%0d got %0d want %0d", c, free_count, NUM_CKPT - q.size()); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alloc_pair();
    test_full();
    test_chain_mispred();
    test_dual_mispred();
    test_clear_and_mispred();
    test_flush_alloc();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
